// File: rtl/ahb_dot_product_acc.sv
// ahb_dot_product_acc: AHB-Lite slave computing a running signed dot product.
// Core writes 16x16 sample pairs to DATA_IN. A small FIFO decouples bus
// writes from an iterative MUL/ACC datapath. The accumulator and MAC count
// are readable over the bus.
// Optional feature macro: DOT_ACC_SATURATE_EN.
//   Defined:   the accumulator saturates and STATUS[3] is a sticky SAT flag.
//   Undefined: the accumulator wraps and STATUS[3] reads 0.
module ahb_dot_product_acc #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned ACC_WIDTH  = 48
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned CNT_W = 4;

  // Word offsets (HADDR[7:2])
  localparam logic [5:0] A_CTRL   = 6'h00;
  localparam logic [5:0] A_STATUS = 6'h01;
  localparam logic [5:0] A_DATA   = 6'h02;
  localparam logic [5:0] A_ACC_LO = 6'h03;
  localparam logic [5:0] A_ACC_HI = 6'h04;
  localparam logic [5:0] A_COUNT  = 6'h05;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_ACC  = 2'd2
  } state_t;

  // Address-phase capture
  logic                        r_dp_valid;
  logic                        r_dp_write;
  logic [5:0]                  r_dp_addr;

  // FIFO
  logic signed [15:0]          r_fifo_a [FIFO_DEPTH];
  logic signed [15:0]          r_fifo_b [FIFO_DEPTH];
  logic [PTR_W-1:0]            r_wr_ptr;
  logic [PTR_W-1:0]            r_rd_ptr;
  logic [LVL_W-1:0]            r_level;

  // FSM and datapath
  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [CNT_W-1:0]            r_cnt;
  logic signed [15:0]          r_op_a;
  logic signed [15:0]          r_op_b;
  logic signed [31:0]          r_prod;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic [31:0]                 r_count;

  logic                        w_full;
  logic                        w_empty;
  logic                        w_busy;
  logic                        w_dp_data_wr;
  logic                        w_push;
  logic                        w_clear;
  logic                        w_pop;
  logic                        w_prod_en;
  logic                        w_acc_en;
  logic                        w_sat;
  logic signed [31:0]          w_mul;
  logic signed [ACC_WIDTH-1:0] w_prod_ext;
  logic signed [ACC_WIDTH-1:0] w_acc_nxt;
  logic signed [63:0]          w_acc_sx;
  logic                        w_unused;

  // Only HADDR[7:2] is decoded and HSIZE is ignored
  assign w_unused = ^{HSIZE, HADDR[31:8], HADDR[1:0]};

  // Register the address phase; held while the bus is stalled
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_dp_valid <= 1'b0;
      r_dp_write <= 1'b0;
      r_dp_addr  <= '0;
    end else if (HREADY) begin
      r_dp_valid <= HSEL;
      r_dp_write <= HWRITE;
      r_dp_addr  <= HADDR[7:2];
    end
  end

  assign w_full       = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_empty      = (r_level == '0);
  assign w_busy       = !w_empty || (r_state != S_IDLE);
  assign w_dp_data_wr = r_dp_valid && r_dp_write && (r_dp_addr == A_DATA);
  assign w_push       = w_dp_data_wr && !w_full;
  assign w_clear      = r_dp_valid && r_dp_write && (r_dp_addr == A_CTRL) && HWDATA[0];

  // Stall a DATA_IN write until a FIFO slot is free
  assign HREADYOUT = !(w_dp_data_wr && w_full);
  assign HRESP     = 1'b0;

  // FIFO storage; contents need no reset since the level gates every read
  always_ff @(posedge HCLK) begin
    if (w_push) begin
      r_fifo_a[r_wr_ptr] <= HWDATA[31:16];
      r_fifo_b[r_wr_ptr] <= HWDATA[15:0];
    end
  end

  // FIFO pointers and level; CLEAR flushes
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (w_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM next state and datapath strobes; CLEAR aborts everything
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_prod_en   = 1'b0;
    w_acc_en    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_MUL;
        end
      end
      S_MUL: begin
        if (r_cnt == '0) begin
          w_prod_en   = 1'b1;
          w_state_nxt = S_ACC;
        end
      end
      S_ACC: begin
        w_acc_en = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_MUL;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_clear) begin
      w_state_nxt = S_IDLE;
      w_pop       = 1'b0;
      w_prod_en   = 1'b0;
      w_acc_en    = 1'b0;
    end
  end

  // Operand load on pop, MUL cycle counter and product register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_op_a <= '0;
      r_op_b <= '0;
      r_cnt  <= '0;
      r_prod <= '0;
    end else begin
      if (w_pop) begin
        r_op_a <= r_fifo_a[r_rd_ptr];
        r_op_b <= r_fifo_b[r_rd_ptr];
        r_cnt  <= CNT_W'(MUL_CYCLES - 1);
      end else if (r_state == S_MUL && r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_prod_en) r_prod <= w_mul;
    end
  end

  assign w_mul      = 32'(r_op_a) * 32'(r_op_b);
  assign w_prod_ext = ACC_WIDTH'(r_prod);

`ifdef DOT_ACC_SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH:0] w_sum_wide;
  logic                      w_ovf;
  logic                      r_sat;

  assign w_sum_wide = (ACC_WIDTH+1)'(r_acc) + (ACC_WIDTH+1)'(w_prod_ext);
  assign w_ovf      = w_sum_wide[ACC_WIDTH] ^ w_sum_wide[ACC_WIDTH-1];

  // Clamp to the true sign of the wide sum on overflow
  always_comb begin
    w_acc_nxt = w_sum_wide[ACC_WIDTH-1:0];
    if (w_ovf) w_acc_nxt = w_sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
  end

  // Sticky saturation flag
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                r_sat <= 1'b0;
    else if (w_clear)            r_sat <= 1'b0;
    else if (w_acc_en && w_ovf)  r_sat <= 1'b1;
  end

  assign w_sat = r_sat;
`else
  assign w_acc_nxt = r_acc + w_prod_ext;
  assign w_sat     = 1'b0;
`endif

  // Accumulator and completed-MAC count
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_acc   <= '0;
      r_count <= '0;
    end else if (w_clear) begin
      r_acc   <= '0;
      r_count <= '0;
    end else if (w_acc_en) begin
      r_acc   <= w_acc_nxt;
      r_count <= r_count + 32'd1;
    end
  end

  assign w_acc_sx = 64'(r_acc);

  // Zero-wait read mux from register state at the start of the data phase
  always_comb begin
    HRDATA = '0;
    if (r_dp_valid && !r_dp_write) begin
      case (r_dp_addr)
        A_STATUS: HRDATA = {19'd0, 5'(r_level), 4'd0, w_sat, w_empty, w_full, w_busy};
        A_ACC_LO: HRDATA = w_acc_sx[31:0];
        A_ACC_HI: HRDATA = w_acc_sx[63:32];
        A_COUNT:  HRDATA = r_count;
        default:  HRDATA = '0;
      endcase
    end
  end

endmodule
